// File: rtl/sev_seg_pkg.sv
// sev_seg_pkg: shared constants, types and helpers for the 7-segment scan logic
// Contents:
//   SEG_BLANK  all segments off (active low)
//   bcd_t      one BCD digit nibble
//   clog2()    digit-index width for a given digit count
package sev_seg_pkg;
  localparam logic [7:1] SEG_BLANK = 7'b1111111;
  typedef logic [3:0] bcd_t;
  function automatic int clog2(input int n);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/sev_seg_scan_ctrl_if.sv
// sev_seg_scan_ctrl_if: frame-load handshake and display lines of the scan controller
// Signals:
//   value_in, dp_in, load   frame source -> controller
//   load_ack, frame_start   controller status pulses
//   an, seg, dp             active-low display drive
// Modports: master = frame source / display side, slave = controller
interface sev_seg_scan_ctrl_if #(parameter int NUM_DIGITS = 4);
  logic [4*NUM_DIGITS-1:0] value_in;
  logic [NUM_DIGITS-1:0] dp_in;
  logic load;
  logic load_ack;
  logic frame_start;
  logic [NUM_DIGITS-1:0] an;
  logic [7:1] seg;
  logic dp;
  modport master (output value_in, dp_in, load, input load_ack, frame_start, an, seg, dp);
  modport slave (input value_in, dp_in, load, output load_ack, frame_start, an, seg, dp);
endinterface

// File: rtl/sev_seg_decoder.sv
// sev_seg_decoder: BCD nibble to active-low segments, seg[7:1] = g..a
// Ports: bcd in (4), seg out (7); nibbles A-F show the centre bar only
module sev_seg_decoder
  import sev_seg_pkg::*;
(
  input  bcd_t       bcd,
  output logic [7:1] seg
);
  always_comb begin
    case (bcd)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b0111111;
    endcase
  end
endmodule

// File: rtl/sev_seg_scan_ctrl.sv
// sev_seg_scan_ctrl: time-multiplexed scan controller for an N-digit common-anode display
// Ports: clk, rst (sync, active high), bus (sev_seg_scan_ctrl_if.slave):
//   value_in/dp_in/load in, load_ack/frame_start out, an/seg/dp out (active low)
// Option: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown)
// All outputs are registered from the current counter state, so every output lags
// slot_cnt/digit_idx by one cycle; frame_start marks the first (blank) cycle of digit 0.
module sev_seg_scan_ctrl
  import sev_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input logic clk,
  input logic rst,
  sev_seg_scan_ctrl_if.slave bus
);
  localparam int SW = $clog2(REFRESH_DIV);
  localparam int IW = clog2(NUM_DIGITS);
  logic [SW-1:0] slot_cnt;
  logic [IW-1:0] digit_idx;
  logic [4*NUM_DIGITS-1:0] disp, pend;
  logic [NUM_DIGITS-1:0] disp_dp, pend_dp;
  logic pending, copied;
  logic slot_end, boundary, off;
  bcd_t nib;
  logic [7:1] dec_seg;
  assign slot_end = slot_cnt == SW'(REFRESH_DIV - 1);
  assign boundary = slot_end && digit_idx == IW'(NUM_DIGITS - 1);
  assign nib = disp[digit_idx*4 +: 4];
  sev_seg_decoder u_dec (.bcd(nib), .seg(dec_seg));
`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz;
  // lz[i]: digit i and every digit above it are 0 with dp off
  always_comb begin
    logic z;
    lz = '0;
    z = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      z = z && disp[4*i +: 4] == 4'd0 && !disp_dp[i];
      lz[i] = z;
    end
  end
  assign off = slot_cnt < SW'(BLANK_CYCLES) || lz[digit_idx];
`else
  assign off = slot_cnt < SW'(BLANK_CYCLES);
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      digit_idx <= '0;
      disp <= '0;
      disp_dp <= '0;
      pend <= '0;
      pend_dp <= '0;
      pending <= 1'b0;
      copied <= 1'b0;
      bus.load_ack <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.an <= '1;
      bus.seg <= SEG_BLANK;
      bus.dp <= 1'b1;
    end else begin
      slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
      if (slot_end) digit_idx <= digit_idx == IW'(NUM_DIGITS - 1) ? '0 : digit_idx + 1'b1;
      if (bus.load) begin
        pend <= bus.value_in;
        pend_dp <= bus.dp_in;
      end
      if (boundary && pending) begin
        disp <= pend;
        disp_dp <= pend_dp;
      end
      // a load on the boundary cycle re-arms pending for the next frame
      pending <= bus.load || (pending && !boundary);
      // copied holds for the slot-0 cycle so load_ack aligns with frame_start
      copied <= boundary && pending;
      bus.load_ack <= copied;
      bus.frame_start <= slot_cnt == '0 && digit_idx == '0;
      bus.an <= off ? '1 : ~(NUM_DIGITS'(1) << digit_idx);
      bus.seg <= off ? SEG_BLANK : dec_seg;
      bus.dp <= off || !disp_dp[digit_idx];
    end
  end
endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// tb_sev_seg_scan_ctrl: directed self-checking bench, 4 digits, 8-cycle slots, 2 blank cycles
module tb_sev_seg_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif
  always #5 clk = ~clk;
  sev_seg_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();
  sev_seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_frame();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.frame_start && k < 100);
    if (!bus.frame_start) check("frame_start_timeout", bus.frame_start, 1);
  endtask
  task automatic load_frame(input logic [15:0] v, input logic [3:0] d);
    bus.value_in = v;
    bus.dp_in = d;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask
  // called at a frame_start sample; lands on the first lit cycle of digit d
  task automatic show(input int d, input bit lit, input logic [6:0] s, input logic p);
    logic [3:0] a;
    repeat (8 * d + 2) @(negedge clk);
    a = lit ? ~(4'b0001 << d) : 4'b1111;
    check($sformatf("an_d%0d", d), bus.an, a);
    check($sformatf("seg_d%0d", d), bus.seg, lit ? s : 7'h7F);
    check($sformatf("dp_d%0d", d), bus.dp, lit ? p : 1'b1);
  endtask
  logic [6:0] seg1234 [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
  logic [3:0] dp1234 = 4'b0100;
  initial begin
    int acks;
    bus.load = 1'b0;
    bus.value_in = '0;
    bus.dp_in = '0;
    repeat (3) @(negedge clk);
    check("rst_an", bus.an, 4'hF);
    check("rst_seg", bus.seg, 7'h7F);
    check("rst_dp", bus.dp, 1);
    check("rst_ack", bus.load_ack, 0);
    check("rst_fs", bus.frame_start, 0);
    rst = 1'b0;
    @(negedge clk);
    check("first_fs", bus.frame_start, 1);
    check("first_blank", bus.an, 4'hF);
    @(negedge clk);
    check("second_blank", bus.an, 4'hF);
    @(negedge clk);
    check("d0_lit_an", bus.an, 4'b1110);
    check("d0_lit_seg", bus.seg, 7'b1000000);
    check("d0_fs_low", bus.frame_start, 0);
    load_frame(16'h1234, 4'b0100);
    wait_frame();
    check("ack_1234", bus.load_ack, 1);
    show(0, 1, 7'b0011001, 1);
    wait_frame();
    check("ack_once", bus.load_ack, 0);
    show(2, 1, 7'b0100100, 0);
    wait_frame();
    show(3, 1, 7'b1111001, 1);
    wait_frame();
    for (int c = 0; c < 32; c++) begin
      int idx;
      bit blank;
      logic [3:0] a;
      if (c > 0) @(negedge clk);
      idx = c / 8;
      blank = (c % 8) < 2;
      a = blank ? 4'hF : ~(4'b0001 << idx);
      check($sformatf("sweep_an_%0d", c), bus.an, a);
      check($sformatf("sweep_seg_%0d", c), bus.seg, blank ? 7'h7F : seg1234[idx]);
      check($sformatf("sweep_dp_%0d", c), bus.dp, blank ? 1'b1 : !dp1234[idx]);
      check($sformatf("sweep_fs_%0d", c), bus.frame_start, c == 0);
      check($sformatf("sweep_onehot_%0d", c), $countones(~bus.an) <= 1, 1);
    end
    @(negedge clk);
    check("frame_len_32", bus.frame_start, 1);
    repeat (3) @(negedge clk);
    load_frame(16'h1111, 4'b0000);
    repeat (5) @(negedge clk);
    load_frame(16'h2222, 4'b0000);
    wait_frame();
    check("ack_2222", bus.load_ack, 1);
    show(0, 1, 7'b0100100, 1);
    wait_frame();
    check("single_ack", bus.load_ack, 0);
    show(3, 1, 7'b0100100, 1);
    wait_frame();
    repeat (30) @(negedge clk);
    load_frame(16'h5678, 4'b0000);
    wait_frame();
    check("boundary_no_ack", bus.load_ack, 0);
    show(0, 1, 7'b0100100, 1);
    wait_frame();
    check("boundary_ack_next", bus.load_ack, 1);
    show(0, 1, 7'b0000000, 1);
    repeat (4) @(negedge clk);
    load_frame(16'h9999, 4'b1111);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_an", bus.an, 4'hF);
    check("midrst_ack", bus.load_ack, 0);
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      acks += int'(bus.load_ack);
    end
    check("rst_discard_ack", acks, 0);
    wait_frame();
    show(0, 1, 7'b1000000, 1);
    wait_frame();
    show(3, !LZ, 7'b1000000, 1);
    load_frame(16'h0070, 4'b0000);
    wait_frame();
    check("ack_0070", bus.load_ack, 1);
    show(3, !LZ, 7'b1000000, 1);
    wait_frame();
    show(2, !LZ, 7'b1000000, 1);
    wait_frame();
    show(1, 1, 7'b1111000, 1);
    wait_frame();
    show(0, 1, 7'b1000000, 1);
    load_frame(16'h0000, 4'b0000);
    wait_frame();
    check("ack_0000", bus.load_ack, 1);
    show(0, 1, 7'b1000000, 1);
    wait_frame();
    show(1, !LZ, 7'b1000000, 1);
    load_frame(16'h00A5, 4'b0000);
    wait_frame();
    check("ack_00a5", bus.load_ack, 1);
    show(1, 1, 7'b0111111, 1);
    wait_frame();
    show(0, 1, 7'b0010010, 1);
    wait_frame();
    show(2, !LZ, 7'b1000000, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
